// File: rtl/coin_change_dispenser_pkg.sv
// Shared vending constants: coin values, payout FSM state codes and coin-eject codes.
package vend_pkg;

    localparam int NICKEL_C = 5;
    localparam int DIME_C   = 10;

    typedef logic [1:0] state_t;

    localparam state_t IDLE     = 2'd0;
    localparam state_t PAY      = 2'd1;
    localparam state_t GAP_WAIT = 2'd2;
    localparam state_t FIN      = 2'd3;

    typedef enum logic [1:0] {
        COIN_NONE   = 2'd0,
        COIN_NICKEL = 2'd1,
        COIN_DIME   = 2'd2
    } coin_e;

endpackage

// File: rtl/coin_change_dispenser_tube.sv
// One coin tube stock counter: loads full, decrements per ejected coin, sticks at zero.
module coin_tube #(
    parameter int CNT_W = 5,
    parameter int FULL  = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             empty
);

    // Reset and refill both reload the tube; an empty tube never wraps.
    always_ff @(posedge clk) begin
        if (!rst || load) begin
            cnt <= CNT_W'(FULL);
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign empty = (cnt == '0);

endmodule

// File: rtl/coin_change_dispenser.sv
// Change payout controller: takes a cent amount and ejects dimes first, then nickels,
// with a fixed idle gap after every coin. Reports short payment and the unpaid amount.
//
//  state    | meaning
//  ---------+----------------------------------------------------------
//  IDLE     | ready for a request; refill honoured here only
//  PAY      | one-cycle decision: eject a dime, a nickel, or finish
//  GAP_WAIT | eject line low for GAP cycles after a coin pulse
//  FIN      | done (and short) pulse cycle, back to IDLE next
module coin_change_dispenser
    import vend_pkg::*;
#(
    parameter int AMT_W       = 6,
    parameter int CNT_W       = 5,
    parameter int NICKEL_FULL = 20,
    parameter int DIME_FULL   = 20,
    parameter int GAP         = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amt,
    output logic             req_ready,
    input  logic             refill,
    output logic             nickel_out,
    output logic             dime_out,
    output logic             busy,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] owed,
    output logic [CNT_W-1:0] nickel_cnt,
    output logic [CNT_W-1:0] dime_cnt
);

    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    state_t           state;
    coin_e            coin;
    logic [AMT_W-1:0] rem;
    logic [AMT_W-1:0] owed_r;
    logic [AMT_W-1:0] amt_trunc;
    logic [GAP_W-1:0] gap_cnt;
    logic             short_r;
    logic             accept;
    logic             tube_load;
    logic             pay_dime;
    logic             pay_nickel;
    logic             nickel_empty;
    logic             dime_empty;

    // Odd cents below a nickel cannot be paid and are dropped at acceptance.
    assign amt_trunc = req_amt - (req_amt % AMT_W'(NICKEL_C));

    assign req_ready  = (state == IDLE) & rst & ~refill;
    assign accept     = req_valid & req_ready;
    assign tube_load  = (state == IDLE) & refill;

    // A coin is only ejected if it does not overpay and its tube has stock.
    assign pay_dime   = (state == PAY) && (rem >= AMT_W'(DIME_C)) && !dime_empty;
    assign pay_nickel = (state == PAY) && !pay_dime &&
                        (rem >= AMT_W'(NICKEL_C)) && !nickel_empty;

    coin_tube #(
        .CNT_W (CNT_W),
        .FULL  (NICKEL_FULL)
    ) u_nickel_tube (
        .clk   (clk),
        .rst   (rst),
        .load  (tube_load),
        .dec   (pay_nickel),
        .cnt   (nickel_cnt),
        .empty (nickel_empty)
    );

    coin_tube #(
        .CNT_W (CNT_W),
        .FULL  (DIME_FULL)
    ) u_dime_tube (
        .clk   (clk),
        .rst   (rst),
        .load  (tube_load),
        .dec   (pay_dime),
        .cnt   (dime_cnt),
        .empty (dime_empty)
    );

    // Payout sequencing with registered coin code, short flag and owed amount.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            coin    <= COIN_NONE;
            rem     <= '0;
            owed_r  <= '0;
            gap_cnt <= '0;
            short_r <= 1'b0;
        end else begin
            coin    <= COIN_NONE;
            short_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        rem    <= amt_trunc;
                        owed_r <= '0;
                        state  <= PAY;
                    end
                end
                PAY: begin
                    if (pay_dime) begin
                        coin    <= COIN_DIME;
                        rem     <= rem - AMT_W'(DIME_C);
                        gap_cnt <= GAP_W'(GAP - 1);
                        state   <= GAP_WAIT;
                    end else if (pay_nickel) begin
                        coin    <= COIN_NICKEL;
                        rem     <= rem - AMT_W'(NICKEL_C);
                        gap_cnt <= GAP_W'(GAP - 1);
                        state   <= GAP_WAIT;
                    end else begin
                        state <= FIN;
                        if (rem != '0) begin
                            short_r <= 1'b1;
                            owed_r  <= rem;
                        end
                    end
                end
                GAP_WAIT: begin
                    if (gap_cnt == '0) begin
                        state <= PAY;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign nickel_out = (coin == COIN_NICKEL);
    assign dime_out   = (coin == COIN_DIME);
    assign busy       = (state != IDLE);
    assign done       = (state == FIN);
    assign short      = short_r;
    assign owed       = owed_r;

endmodule
